// File: rtl/tron_pkg.sv
// Shared constants, state encodings and requester ids for the Tron plot arbiter.
// The field is 100x100 pixels; coordinates above X_MAX/Y_MAX are off-screen.
package tron_pkg;

  localparam int X_W   = 7;
  localparam int Y_W   = 7;
  localparam int COL_W = 3;

  localparam logic [X_W-1:0]   X_MAX     = 7'd99;
  localparam logic [Y_W-1:0]   Y_MAX     = 7'd99;
  localparam logic [COL_W-1:0] BG_COLOUR = 3'b000;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  typedef enum logic {
    P1 = 1'b0,
    P2 = 1'b1
  } req_id_e;

  function automatic logic in_field(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (x <= X_MAX) && (y <= Y_MAX);
  endfunction

endpackage

// File: rtl/tron_plot_arbiter_if.sv
// Bundle of the player request channels, clear control and VGA write port.
// The arbiter is the slave; the game top (or bench) drives the master side.
interface tron_plot_arbiter_if;
  import tron_pkg::*;

  logic             clear_req;
  logic             clear_busy;

  logic             p1_req;
  logic [X_W-1:0]   p1_x;
  logic [Y_W-1:0]   p1_y;
  logic [COL_W-1:0] p1_colour;
  logic             p1_grant;

  logic             p2_req;
  logic [X_W-1:0]   p2_x;
  logic [Y_W-1:0]   p2_y;
  logic [COL_W-1:0] p2_colour;
  logic             p2_grant;

  logic [X_W-1:0]   vga_x;
  logic [Y_W-1:0]   vga_y;
  logic [COL_W-1:0] vga_colour;
  logic             vga_plot;
  logic             oob_err;

  modport master (
    output clear_req,
    output p1_req, p1_x, p1_y, p1_colour,
    output p2_req, p2_x, p2_y, p2_colour,
    input  clear_busy, p1_grant, p2_grant,
    input  vga_x, vga_y, vga_colour, vga_plot, oob_err
  );

  modport slave (
    input  clear_req,
    input  p1_req, p1_x, p1_y, p1_colour,
    input  p2_req, p2_x, p2_y, p2_colour,
    output clear_busy, p1_grant, p2_grant,
    output vga_x, vga_y, vga_colour, vga_plot, oob_err
  );

endinterface

// File: rtl/tron_clear_counter.sv
// Raster x/y counter for the screen clear, x fastest, wrapping to (0,0) after the last pixel.
// start forces (0,0); en advances by one pixel; last flags (X_MAX, Y_MAX).
module tron_clear_counter
  import tron_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           en,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign last = (x_q == X_MAX) && (y_q == Y_MAX);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (start) begin
      x_d = '0;
      y_d = '0;
    end else if (en) begin
      if (x_q == X_MAX) begin
        x_d = '0;
        y_d = last ? '0 : y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
      end
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/tron_plot_arbiter.sv
// Sole owner of the VGA write port: round-robin between the two players, with a
// full-screen clear sweep taking priority. All outputs come straight from flops.
module tron_plot_arbiter
  import tron_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  tron_plot_arbiter_if.slave bus
);

  state_e           state_q, state_d;
  req_id_e          rr_q, rr_d;
  logic             p1_grant_q, p1_grant_d;
  logic             p2_grant_q, p2_grant_d;
  logic [X_W-1:0]   vga_x_q, vga_x_d;
  logic [Y_W-1:0]   vga_y_q, vga_y_d;
  logic [COL_W-1:0] vga_colour_q, vga_colour_d;
  logic             vga_plot_q, vga_plot_d;
  logic             clear_busy_q, clear_busy_d;
  logic             oob_err_q, oob_err_d;

  logic             cnt_start, cnt_en, cnt_last;
  logic [X_W-1:0]   cnt_x;
  logic [Y_W-1:0]   cnt_y;

  logic             p1_elig, p2_elig, win_valid;
  req_id_e          win_id;
  logic [X_W-1:0]   win_x;
  logic [Y_W-1:0]   win_y;
  logic [COL_W-1:0] win_colour;

  tron_clear_counter u_clear_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (cnt_start),
    .en      (cnt_en),
    .x       (cnt_x),
    .y       (cnt_y),
    .last    (cnt_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rr_q         <= P2;
      p1_grant_q   <= 1'b0;
      p2_grant_q   <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      clear_busy_q <= 1'b0;
      oob_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      p1_grant_q   <= p1_grant_d;
      p2_grant_q   <= p2_grant_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      clear_busy_q <= clear_busy_d;
      oob_err_q    <= oob_err_d;
    end
  end

  // A player granted this cycle sits out the edge that ends the grant cycle.
  always_comb begin
    p1_elig   = bus.p1_req & ~p1_grant_q;
    p2_elig   = bus.p2_req & ~p2_grant_q;
    win_valid = p1_elig | p2_elig;
    if (p1_elig && p2_elig) begin
      win_id = (rr_q == P1) ? P2 : P1;
    end else if (p1_elig) begin
      win_id = P1;
    end else begin
      win_id = P2;
    end
    win_x      = (win_id == P1) ? bus.p1_x      : bus.p2_x;
    win_y      = (win_id == P1) ? bus.p1_y      : bus.p2_y;
    win_colour = (win_id == P1) ? bus.p1_colour : bus.p2_colour;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.clear_req) state_d = CLEAR;
      CLEAR:   if (cnt_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The counter idles at (0,0), so the edge that starts a clear emits it directly.
  always_comb begin
    p1_grant_d   = 1'b0;
    p2_grant_d   = 1'b0;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    clear_busy_d = 1'b0;
    oob_err_d    = oob_err_q;
    rr_d         = rr_q;
    cnt_start    = 1'b0;
    cnt_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clear_req) begin
          vga_x_d      = cnt_x;
          vga_y_d      = cnt_y;
          vga_colour_d = BG_COLOUR;
          vga_plot_d   = 1'b1;
          clear_busy_d = 1'b1;
          cnt_en       = 1'b1;
        end else begin
          cnt_start = 1'b1;
          if (win_valid) begin
            p1_grant_d   = (win_id == P1);
            p2_grant_d   = (win_id == P2);
            rr_d         = win_id;
            vga_x_d      = win_x;
            vga_y_d      = win_y;
            vga_colour_d = win_colour;
            if (in_field(win_x, win_y)) begin
              vga_plot_d = 1'b1;
            end else begin
              oob_err_d = 1'b1;
            end
          end
        end
      end
      CLEAR: begin
        vga_x_d      = cnt_x;
        vga_y_d      = cnt_y;
        vga_colour_d = BG_COLOUR;
        vga_plot_d   = 1'b1;
        clear_busy_d = 1'b1;
        cnt_en       = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.p1_grant   = p1_grant_q;
  assign bus.p2_grant   = p2_grant_q;
  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_colour_q;
  assign bus.vga_plot   = vga_plot_q;
  assign bus.clear_busy = clear_busy_q;
  assign bus.oob_err    = oob_err_q;

endmodule

// File: tb/tb_tron_plot_arbiter.sv
// Bench for tron_plot_arbiter: directed scenarios plus randomized player traffic,
// all checked against a pixel-index / last-served reference model.
module tb_tron_plot_arbiter;
  import tron_pkg::*;

  logic clk;
  logic reset_n;
  int   tests_run    = 0;
  int   tests_failed = 0;

  tron_plot_arbiter_if bus();

  tron_plot_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int         m_last;
  bit         m_g1, m_g2, m_clearing;
  int         m_idx;
  logic [6:0] e_x, e_y;
  logic [2:0] e_c;
  bit         e_p1g, e_p2g, e_plot, e_busy, e_oob;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [21:0] dut_vec();
    return {bus.p1_grant, bus.p2_grant, bus.vga_x, bus.vga_y, bus.vga_colour,
            bus.vga_plot, bus.clear_busy, bus.oob_err};
  endfunction

  function automatic logic [21:0] exp_vec();
    return {e_p1g, e_p2g, e_x, e_y, e_c, e_plot, e_busy, e_oob};
  endfunction

  task automatic model_reset();
    m_last = 2; m_g1 = 0; m_g2 = 0; m_clearing = 0; m_idx = 0;
    e_x = '0; e_y = '0; e_c = '0;
    e_p1g = 0; e_p2g = 0; e_plot = 0; e_busy = 0; e_oob = 0;
  endtask

  task automatic drive_idle();
    bus.clear_req = 1'b0;
    bus.p1_req = 1'b0; bus.p1_x = '0; bus.p1_y = '0; bus.p1_colour = '0;
    bus.p2_req = 1'b0; bus.p2_x = '0; bus.p2_y = '0; bus.p2_colour = '0;
  endtask

  task automatic reset_dut();
    drive_idle();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Advance the model by one edge from the inputs currently driven, then the DUT.
  task automatic tick();
    bit         el1, el2;
    int         w, wx, wy;
    logic [2:0] wc;
    if (!m_clearing && bus.clear_req) begin
      m_clearing = 1;
      m_idx      = 0;
    end
    e_p1g = 0;
    e_p2g = 0;
    if (m_clearing) begin
      e_x = 7'(m_idx % 100);
      e_y = 7'(m_idx / 100);
      e_c = 3'b000;
      e_plot = 1;
      e_busy = 1;
      m_idx++;
      if (m_idx == 10000) m_clearing = 0;
    end else begin
      el1 = bus.p1_req && !m_g1;
      el2 = bus.p2_req && !m_g2;
      w = 0;
      if (el1 && el2) w = (m_last == 1) ? 2 : 1;
      else if (el1)   w = 1;
      else if (el2)   w = 2;
      e_busy = 0;
      e_plot = 0;
      if (w != 0) begin
        wx = (w == 1) ? int'(bus.p1_x) : int'(bus.p2_x);
        wy = (w == 1) ? int'(bus.p1_y) : int'(bus.p2_y);
        wc = (w == 1) ? bus.p1_colour : bus.p2_colour;
        e_x = 7'(wx);
        e_y = 7'(wy);
        e_c = wc;
        if (wx < 100 && wy < 100) e_plot = 1;
        else                      e_oob  = 1;
        m_last = w;
      end
      e_p1g = (w == 1);
      e_p2g = (w == 2);
    end
    m_g1 = e_p1g;
    m_g2 = e_p2g;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_dut();
    bus.p1_req = 1'b1; bus.p1_x = 7'd3; bus.p1_y = 7'd4; bus.p1_colour = 3'b111;
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (dut_vec() !== 22'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_async: got %h expected %h", dut_vec(), 22'd0);
    end
    drive_idle();
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    tests_run++;
    if (dut_vec() !== 22'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_idle: got %h expected %h", dut_vec(), 22'd0);
    end
    bus.p1_req = 1'b1; bus.p1_x = 7'd1; bus.p1_y = 7'd2; bus.p1_colour = 3'b001;
    bus.p2_req = 1'b1; bus.p2_x = 7'd8; bus.p2_y = 7'd9; bus.p2_colour = 3'b010;
    tick();
    tests_run++;
    if ({bus.p1_grant, bus.p2_grant} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL first_tie: got grants %b expected %b", {bus.p1_grant, bus.p2_grant}, 2'b10);
    end
    tests_run++;
    if (dut_vec() !== exp_vec()) begin
      tests_failed++;
      $display("[TB] FAIL first_tie_model: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_p1_only();
    reset_dut();
    bus.p1_req = 1'b1; bus.p1_x = 7'd5; bus.p1_y = 7'd7; bus.p1_colour = 3'b100;
    tick();
    tests_run++;
    if ({bus.p1_grant, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour} !==
        {1'b1, 1'b1, 7'd5, 7'd7, 3'b100}) begin
      tests_failed++;
      $display("[TB] FAIL p1_only_grant: got g=%b plot=%b (%0d,%0d,%b) expected g=1 plot=1 (5,7,100)",
               bus.p1_grant, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour);
    end
    tick();
    tests_run++;
    if ({bus.p1_grant, bus.vga_plot} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL p1_only_gap: got grant/plot %b expected 00", {bus.p1_grant, bus.vga_plot});
    end
    tick();
    tests_run++;
    if (bus.p1_grant !== 1'b1 || dut_vec() !== exp_vec()) begin
      tests_failed++;
      $display("[TB] FAIL p1_only_regrant: got %h expected %h", dut_vec(), exp_vec());
    end
    bus.p1_req = 1'b0;
    tick();
  endtask

  task automatic test_alternate();
    reset_dut();
    bus.p1_req = 1'b1; bus.p1_x = 7'd10; bus.p1_y = 7'd11; bus.p1_colour = 3'b001;
    bus.p2_req = 1'b1; bus.p2_x = 7'd20; bus.p2_y = 7'd21; bus.p2_colour = 3'b010;
    for (int i = 0; i < 12; i++) begin
      tick();
      tests_run++;
      if ({bus.p1_grant, bus.p2_grant, bus.vga_plot} !== ((i % 2 == 0) ? 3'b101 : 3'b011) ||
          dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL alternate_%0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
      if (bus.p1_grant) begin
        bus.p1_x = 7'($urandom_range(0, 99)); bus.p1_y = 7'($urandom_range(0, 99));
        bus.p1_colour = 3'($urandom_range(0, 7));
      end
      if (bus.p2_grant) begin
        bus.p2_x = 7'($urandom_range(0, 99)); bus.p2_y = 7'($urandom_range(0, 99));
        bus.p2_colour = 3'($urandom_range(0, 7));
      end
    end
    drive_idle();
    tick();
  endtask

  task automatic test_clear();
    int         plots, bad, early, guard;
    logic [6:0] lx, ly;
    reset_dut();
    bus.p2_req = 1'b1; bus.p2_x = 7'd10; bus.p2_y = 7'd20; bus.p2_colour = 3'b101;
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    tests_run++;
    if ({bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot, bus.clear_busy, bus.p2_grant} !==
        {7'd0, 7'd0, 3'b000, 1'b1, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL clear_first: got (%0d,%0d,%b) plot=%b busy=%b g2=%b expected (0,0,000) plot=1 busy=1 g2=0",
               bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot, bus.clear_busy, bus.p2_grant);
    end
    plots = 1; bad = 0; early = 0; guard = 0;
    lx = bus.vga_x; ly = bus.vga_y;
    while (bus.clear_busy === 1'b1 && guard < 10100) begin
      bus.clear_req = (guard == 100);
      tick();
      guard++;
      if (dut_vec() !== exp_vec()) bad++;
      if (bus.clear_busy === 1'b1) begin
        if (bus.vga_plot === 1'b1) plots++;
        if (bus.p2_grant !== 1'b0) early++;
        lx = bus.vga_x; ly = bus.vga_y;
      end
    end
    bus.clear_req = 1'b0;
    tests_run++;
    if (plots != 10000) begin
      tests_failed++;
      $display("[TB] FAIL clear_count: got %0d plot cycles expected 10000", plots);
    end
    tests_run++;
    if ({lx, ly} !== {7'd99, 7'd99}) begin
      tests_failed++;
      $display("[TB] FAIL clear_last: got (%0d,%0d) expected (99,99)", lx, ly);
    end
    tests_run++;
    if (bad != 0 || early != 0) begin
      tests_failed++;
      $display("[TB] FAIL clear_sweep: got %0d model differences and %0d grants during clear expected 0 and 0", bad, early);
    end
    tests_run++;
    if (bus.p2_grant !== 1'b1 || bus.clear_busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL clear_then_p2: got g2=%b busy=%b expected g2=1 busy=0", bus.p2_grant, bus.clear_busy);
    end
    bus.p2_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_clear();
    int bad;
    reset_dut();
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    repeat (5000) tick();
    tests_run++;
    if ({bus.vga_x, bus.vga_y, bus.clear_busy} !== {7'd0, 7'd50, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL midclear_pixel: got (%0d,%0d) busy=%b expected (0,50) busy=1",
               bus.vga_x, bus.vga_y, bus.clear_busy);
    end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.clear_busy, bus.vga_plot} !== 2'b00 || dut_vec() !== 22'd0) begin
      tests_failed++;
      $display("[TB] FAIL midclear_abort: got %h expected %h", dut_vec(), 22'd0);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.clear_busy !== 1'b0 || bus.vga_plot !== 1'b0 || dut_vec() !== exp_vec()) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL midclear_no_resume: got %0d active cycles expected 0", bad);
    end
  endtask

  task automatic test_oob();
    reset_dut();
    bus.p2_req = 1'b1; bus.p2_x = 7'd100; bus.p2_y = 7'd3; bus.p2_colour = 3'b111;
    tick();
    bus.p2_req = 1'b0;
    tests_run++;
    if ({bus.p2_grant, bus.vga_plot, bus.oob_err} !== 3'b101) begin
      tests_failed++;
      $display("[TB] FAIL oob_hit: got g2/plot/oob %b expected 101", {bus.p2_grant, bus.vga_plot, bus.oob_err});
    end
    repeat (5) tick();
    tests_run++;
    if (bus.oob_err !== 1'b1 || dut_vec() !== exp_vec()) begin
      tests_failed++;
      $display("[TB] FAIL oob_sticky: got %h expected %h", dut_vec(), exp_vec());
    end
    bus.p1_req = 1'b1; bus.p1_x = 7'd1; bus.p1_y = 7'd1; bus.p1_colour = 3'b010;
    tick();
    bus.p1_req = 1'b0;
    tests_run++;
    if ({bus.p1_grant, bus.vga_plot, bus.oob_err} !== 3'b111) begin
      tests_failed++;
      $display("[TB] FAIL oob_after_valid: got g1/plot/oob %b expected 111", {bus.p1_grant, bus.vga_plot, bus.oob_err});
    end
    tick();
  endtask

  task automatic test_random();
    int bad;
    reset_dut();
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        if (bad < 5) $display("[TB] FAIL random_cycle_%0d: got %h expected %h", i, dut_vec(), exp_vec());
        bad++;
      end
      if (bus.p1_grant === 1'b1) begin
        bus.p1_req = 1'($urandom_range(0, 1));
        bus.p1_x = 7'($urandom_range(0, 109)); bus.p1_y = 7'($urandom_range(0, 109));
        bus.p1_colour = 3'($urandom_range(0, 7));
      end else if (!bus.p1_req && $urandom_range(0, 2) == 0) begin
        bus.p1_req = 1'b1;
        bus.p1_x = 7'($urandom_range(0, 109)); bus.p1_y = 7'($urandom_range(0, 109));
        bus.p1_colour = 3'($urandom_range(0, 7));
      end
      if (bus.p2_grant === 1'b1) begin
        bus.p2_req = 1'($urandom_range(0, 1));
        bus.p2_x = 7'($urandom_range(0, 109)); bus.p2_y = 7'($urandom_range(0, 109));
        bus.p2_colour = 3'($urandom_range(0, 7));
      end else if (!bus.p2_req && $urandom_range(0, 2) == 0) begin
        bus.p2_req = 1'b1;
        bus.p2_x = 7'($urandom_range(0, 109)); bus.p2_y = 7'($urandom_range(0, 109));
        bus.p2_colour = 3'($urandom_range(0, 7));
      end
    end
    drive_idle();
  endtask

  initial begin
    reset_n = 1'b0;
    drive_idle();
    model_reset();
    test_reset();
    test_p1_only();
    test_alternate();
    test_clear();
    test_reset_mid_clear();
    test_oob();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
